// File: rtl/shift_sequencer.sv
// shift_sequencer: one-bit-per-clock SLL/SRL/SRA shifter with req/ready in, valid/ack out and busy stall; define SHIFT_SEQ_ROTATE_EN to make op 11 ROL (otherwise SLL)
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req,
  output logic               ready,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHAMT_W-1:0] one = 1;
  state_t state, state_n;
  logic [WIDTH-1:0] work, step;
  logic [SHAMT_W-1:0] count;
  logic [1:0] op_q;
  always_comb begin
`ifdef SHIFT_SEQ_ROTATE_EN
    step = op_q == 2'b01 ? {1'b0, work[WIDTH-1:1]} :
           op_q == 2'b10 ? {work[WIDTH-1], work[WIDTH-1:1]} :
           op_q == 2'b11 ? {work[WIDTH-2:0], work[WIDTH-1]} :
                           {work[WIDTH-2:0], 1'b0};
`else
    step = op_q == 2'b01 ? {1'b0, work[WIDTH-1:1]} :
           op_q == 2'b10 ? {work[WIDTH-1], work[WIDTH-1:1]} :
                           {work[WIDTH-2:0], 1'b0};
`endif
  end
  always_comb begin
    state_n = state;
    ready = state == IDLE;
    busy = state == SHIFT;
    result_valid = state == DONE;
    state_n = state == IDLE  ? (req ? SHIFT : IDLE) :
              state == SHIFT ? (count == '0 ? DONE : SHIFT) :
                               (result_ack ? IDLE : DONE);
  end
  assign result = work;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      work <= '0;
      count <= '0;
      op_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        work <= operand;
        count <= shamt;
        op_q <= op;
      end else if (state == SHIFT && count != '0) begin
        work <= step;
        count <= count - one;
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven and scoreboard checks of shift_sequencer
module tb_shift_sequencer;
  logic clock = 0, reset_n = 0, req = 0, result_ack = 0;
  logic [1:0] op = 0;
  logic [4:0] shamt = 0;
  logic [31:0] operand = 0, result;
  logic ready, result_valid, busy;
  int nerr = 0, nchk = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic [1:0] op;
    logic [4:0] sh;
    logic [31:0] a;
    logic [31:0] e;
    int hold;
  } vec_t;
  vec_t tbl[9];
  shift_sequencer dut (
    .clock(clock), .reset_n(reset_n), .req(req), .ready(ready), .op(op),
    .shamt(shamt), .operand(operand), .result(result),
    .result_valid(result_valid), .result_ack(result_ack), .busy(busy)
  );
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input int s, input logic [31:0] x);
    if (o == 2'd1) return x >> s;
    if (o == 2'd2) return $signed(x) >>> s;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (o == 2'd3) return (x << s) | (x >> (32 - s));
`endif
    return x << s;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] a,
                        input logic [31:0] e, input int hold);
    int cyc = 0, bc = 0;
    logic [31:0] r, x;
    check("ready_before_req", ready, 1);
    req = 1; op = o; shamt = s; operand = a;
    exp_q.push_back(e);
    @(negedge clock);
    op = ~o; shamt = ~s; operand = ~a;
    check("ready_in_shift", ready, 0);
    while (!result_valid && cyc < 100) begin
      if (busy) bc++;
      @(negedge clock);
      cyc++;
    end
    check("latency", cyc, 32'(s) + 1);
    check("busy_cycles", bc, 32'(s) + 1);
    check("busy_in_done", busy, 0);
    x = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("result", result, x);
    r = result;
    repeat (hold) begin
      @(negedge clock);
      check("hold_result", result, r);
      check("hold_valid", result_valid, 1);
    end
    result_ack = 1;
    @(negedge clock);
    result_ack = 0;
    req = 0;
    check("ready_after_ack", ready, 1);
    check("valid_after_ack", result_valid, 0);
  endtask
  initial begin
    logic seen_valid;
    tbl[0] = '{2'd0, 5'd4,  32'h0000_00F1, 32'h0000_0F10, 0};
    tbl[1] = '{2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0};
    tbl[2] = '{2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 0};
    tbl[3] = '{2'd2, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 10};
`ifdef SHIFT_SEQ_ROTATE_EN
    tbl[4] = '{2'd3, 5'd4,  32'hF000_0001, 32'h0000_001F, 0};
`else
    tbl[4] = '{2'd3, 5'd4,  32'hF000_0001, 32'h0000_0010, 0};
`endif
    tbl[5] = '{2'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 0};
    tbl[6] = '{2'd2, 5'd4,  32'h7FFF_FFFF, 32'h07FF_FFFF, 0};
    tbl[7] = '{2'd2, 5'd3,  32'hF000_0000, 32'hFE00_0000, 0};
    tbl[8] = '{2'd1, 5'd1,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 0};
    repeat (2) @(negedge clock);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", result, 0);
    reset_n = 1;
    @(negedge clock);
    check("idle_ready", ready, 1);
    check("idle_valid", result_valid, 0);
    result_ack = 1;
    @(negedge clock);
    result_ack = 0;
    check("ack_in_idle_ready", ready, 1);
    check("ack_in_idle_busy", busy, 0);
    for (int i = 0; i < 9; i++) run_op(tbl[i].op, tbl[i].sh, tbl[i].a, tbl[i].e, tbl[i].hold);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] o;
      logic [4:0] s;
      logic [31:0] a;
      o = 2'($urandom_range(0, 3));
      s = 5'($urandom_range(0, 31));
      a = $urandom;
      run_op(o, s, a, model(o, int'(s), a), 1);
    end
    req = 1; op = 2'd0; shamt = 5'd8; operand = 32'h0000_0001;
    @(negedge clock);
    req = 0;
    repeat (6) @(negedge clock);
    check("mid_busy_before_reset", busy, 1);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    check("mid_reset_ready", ready, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_valid", result_valid, 0);
    check("mid_reset_result", result, 0);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clock);
      if (result_valid || busy) seen_valid = 1;
    end
    check("no_valid_after_reset", seen_valid, 0);
    run_op(2'd0, 5'd2, 32'h0000_0003, 32'h0000_000C, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
